// File: rtl/tic_tac_toe_game_pkg.sv
// Shared types for the tic-tac-toe referee:
// cell/winner encodings, FSM states and the win-line table.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    PLAYER = 2'b01,
    COMP   = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    P_WIN = 2'b01,
    C_WIN = 2'b10,
    DRAW  = 2'b11
  } who_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COMPUTER = 2'b01,
    DONE     = 2'b10
  } state_t;

  localparam int NCELLS = 9;
  localparam int NLINES = 8;

  // rows, columns, then the two diagonals
  localparam logic [3:0] WIN_LINES [NLINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/tic_tac_toe_game_if.sv
// Move inputs and board/winner outputs of the referee.
// slave = referee side, master = move source / display side.
interface ttt_if;

  logic       play;
  logic       pc;
  logic [3:0] player_position;
  logic [3:0] computer_position;
  logic [1:0] pos1, pos2, pos3;
  logic [1:0] pos4, pos5, pos6;
  logic [1:0] pos7, pos8, pos9;
  logic [1:0] who;

  modport slave (
    input  play, pc,
    input  player_position,
    input  computer_position,
    output pos1, pos2, pos3,
    output pos4, pos5, pos6,
    output pos7, pos8, pos9,
    output who
  );

  modport master (
    output play, pc,
    output player_position,
    output computer_position,
    input  pos1, pos2, pos3,
    input  pos4, pos5, pos6,
    input  pos7, pos8, pos9,
    input  who
  );

endinterface

// File: rtl/tic_tac_toe_game_win_detect.sv
// Combinational winner decode: any full line of one mark wins,
// a full board without a line is a draw.
module ttt_win_detect
  import ttt_pkg::*;
(
  input  cell_t board_i [NCELLS],
  output who_t  who_o
);

  logic p_win;
  logic c_win;
  logic full;

  always_comb begin
    p_win = 1'b0;
    c_win = 1'b0;
    full  = 1'b1;
    for (int l = 0; l < NLINES; l++) begin
      if (board_i[WIN_LINES[l][0]] == PLAYER &&
          board_i[WIN_LINES[l][1]] == PLAYER &&
          board_i[WIN_LINES[l][2]] == PLAYER)
        p_win = 1'b1;
      if (board_i[WIN_LINES[l][0]] == COMP &&
          board_i[WIN_LINES[l][1]] == COMP &&
          board_i[WIN_LINES[l][2]] == COMP)
        c_win = 1'b1;
    end
    for (int i = 0; i < NCELLS; i++)
      if (board_i[i] == EMPTY)
        full = 1'b0;
  end

  always_comb begin
    who_o = NONE;
    unique case (1'b1)
      p_win:   who_o = P_WIN;
      c_win:   who_o = C_WIN;
      full:    who_o = DRAW;
      default: who_o = NONE;
    endcase
  end

endmodule

// File: rtl/tic_tac_toe_game.sv
// Tic-tac-toe referee: board register, turn FSM and
// move-legality check; winner comes from ttt_win_detect.
module tic_tac_toe_game
  import ttt_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  ttt_if.slave   bus
);

  cell_t  board_q [NCELLS];
  cell_t  board_d [NCELLS];
  state_t state_q, state_d;
  who_t   who_w;

  logic       p_in, c_in;
  logic [3:0] p_idx, c_idx;
  logic       p_ok, c_ok;

  // out-of-range positions must never alias a real cell
  assign p_in  = bus.player_position <= 4'd8;
  assign c_in  = bus.computer_position <= 4'd8;
  assign p_idx = p_in ? bus.player_position : 4'd0;
  assign c_idx = c_in ? bus.computer_position : 4'd0;
  assign p_ok  = p_in && (board_q[p_idx] == EMPTY);
  assign c_ok  = c_in && (board_q[c_idx] == EMPTY);

  ttt_win_detect u_win (
    .board_i (board_q),
    .who_o   (who_w)
  );

  always_comb begin
    board_d = board_q;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (who_w != NONE) begin
          state_d = DONE;
        end else if (bus.play && p_ok) begin
          board_d[p_idx] = PLAYER;
          state_d        = COMPUTER;
        end
      end
      COMPUTER: begin
        if (who_w != NONE) begin
          state_d = DONE;
        end else if (bus.pc && c_ok) begin
          board_d[c_idx] = COMP;
          state_d        = IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      board_q <= '{default: EMPTY};
      state_q <= IDLE;
    end else begin
      board_q <= board_d;
      state_q <= state_d;
    end
  end

  assign bus.pos1 = board_q[0];
  assign bus.pos2 = board_q[1];
  assign bus.pos3 = board_q[2];
  assign bus.pos4 = board_q[3];
  assign bus.pos5 = board_q[4];
  assign bus.pos6 = board_q[5];
  assign bus.pos7 = board_q[6];
  assign bus.pos8 = board_q[7];
  assign bus.pos9 = board_q[8];
  assign bus.who  = who_w;

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Directed bench for tic_tac_toe_game with
// hand-computed boards and winner codes.
module tb_tic_tac_toe_game;

  logic clock = 1'b0;
  logic reset;

  ttt_if bus ();

  tic_tac_toe_game dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;
  logic [1:0] e [9];

  function automatic logic [17:0] obs_board();
    return {bus.pos1, bus.pos2, bus.pos3,
            bus.pos4, bus.pos5, bus.pos6,
            bus.pos7, bus.pos8, bus.pos9};
  endfunction

  function automatic logic [17:0] exp_board();
    return {e[0], e[1], e[2], e[3], e[4],
            e[5], e[6], e[7], e[8]};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [17:0] obs,
                       input logic [17:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag);
    check(tag, obs_board(), exp_board());
  endtask

  task automatic chk_w(input string tag,
                       input logic [1:0] w);
    check(tag, {16'd0, bus.who}, {16'd0, w});
  endtask

  task automatic clr();
    for (int i = 0; i < 9; i++) e[i] = 2'b00;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.play = 1'b0;
    bus.pc = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    clr();
  endtask

  task automatic pmove(input logic [3:0] p);
    bus.play = 1'b1; bus.pc = 1'b0;
    bus.player_position = p;
    step();
    bus.play = 1'b0;
  endtask

  task automatic cmove(input logic [3:0] p);
    bus.pc = 1'b1; bus.play = 1'b0;
    bus.computer_position = p;
    step();
    bus.pc = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.play = 1'b0;
    bus.pc = 1'b0;
    bus.player_position = 4'd0;
    bus.computer_position = 4'd0;
    #1;

    // 1: reset state
    do_reset(10);
    chk_b("reset_board");
    chk_w("reset_who", 2'b00);

    // 2: first moves
    pmove(4'd2); e[2] = 2'b01;
    chk_b("p2");
    cmove(4'd0); e[0] = 2'b10;
    chk_b("c0");

    // 3: computer wins on diagonal 0-4-8
    pmove(4'd6); e[6] = 2'b01;
    cmove(4'd4); e[4] = 2'b10;
    pmove(4'd5); e[5] = 2'b01;
    chk_w("no_win_yet", 2'b00);
    cmove(4'd8); e[8] = 2'b10;
    chk_b("diag_board");
    chk_w("diag_who", 2'b10);
    bus.play = 1'b1; bus.player_position = 4'd1;
    bus.pc = 1'b1; bus.computer_position = 4'd3;
    repeat (4) step();
    chk_b("done_frozen");
    chk_w("done_who", 2'b10);

    // 4: illegal moves
    do_reset(1);
    chk_b("reset2");
    pmove(4'd2); e[2] = 2'b01;
    cmove(4'd0); e[0] = 2'b10;
    pmove(4'd2);
    chk_b("occupied");
    pmove(4'd12);
    chk_b("pos12");
    pmove(4'd9);
    chk_b("pos9");
    pmove(4'd3); e[3] = 2'b01;
    chk_b("legal_after");

    // 5: held play, changing position
    do_reset(1);
    bus.play = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.player_position = 4'(4 + i);
      step();
    end
    bus.play = 1'b0;
    e[4] = 2'b01;
    chk_b("held_play");
    cmove(4'd15);
    chk_b("c_oor");
    cmove(4'd4);
    chk_b("c_occupied");
    cmove(4'd1); e[1] = 2'b10;
    chk_b("c_legal");
    bus.pc = 1'b1; bus.computer_position = 4'd2;
    repeat (3) step();
    bus.pc = 1'b0;
    chk_b("pc_in_idle");

    // 6a: player completes row 0
    do_reset(1);
    pmove(4'd0); cmove(4'd3);
    pmove(4'd1); cmove(4'd4);
    pmove(4'd2);
    e[0] = 2'b01; e[1] = 2'b01; e[2] = 2'b01;
    e[3] = 2'b10; e[4] = 2'b10;
    chk_b("row_board");
    chk_w("row_who", 2'b01);
    cmove(4'd5);
    chk_b("row_frozen");

    // 6b: full board, no line
    do_reset(1);
    pmove(4'd0); cmove(4'd1);
    pmove(4'd2); cmove(4'd4);
    pmove(4'd3); cmove(4'd6);
    pmove(4'd7); cmove(4'd5);
    chk_w("pre_draw", 2'b00);
    pmove(4'd8);
    e = '{2'b01, 2'b10, 2'b01,
          2'b01, 2'b10, 2'b10,
          2'b10, 2'b01, 2'b01};
    chk_b("draw_board");
    chk_w("draw_who", 2'b11);

    // 6c: reset mid-game beats a same-cycle move
    do_reset(1);
    pmove(4'd4); cmove(4'd0);
    reset = 1'b1;
    bus.play = 1'b1; bus.player_position = 4'd1;
    step();
    reset = 1'b0;
    bus.play = 1'b0;
    clr();
    chk_b("mid_reset");
    chk_w("mid_reset_who", 2'b00);
    pmove(4'd7); e[7] = 2'b01;
    chk_b("after_reset");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
